// File: rtl/fdc_arb_pkg.sv
// Shared types and bit positions for the floppy disk command arbiter.
// The macro FDC_ARB_TIMEOUT_EN (see fdc_disk_arbiter) adds a host-answer timeout.
package fdc_arb_pkg;

  localparam int unsigned SR_W  = 32;
  localparam int unsigned CR_W  = 32;
  localparam int unsigned CHS_W = 16;

  typedef enum logic [1:0] {
    OP_SEEK  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  // disk_sr (command word to host) bit positions
  localparam int unsigned SR_ACK       = 16;
  localparam int unsigned SR_READ_LSB  = 17;
  localparam int unsigned SR_WRITE_LSB = 20;
  localparam int unsigned SR_SEEK_LSB  = 24;

  // disk_cr (status word from host) bit positions
  localparam int unsigned CR_SEEK0   = 0;
  localparam int unsigned CR_SEEK1   = 1;
  localparam int unsigned CR_ERR     = 3;
  localparam int unsigned CR_RW_DONE = 4;

  typedef struct packed {
    op_e              op;
    logic [CHS_W-1:0] chs;
  } cmd_t;

  // Position of the unit bit in disk_sr for a given op and drive
  function automatic logic [4:0] unit_bit(input op_e op, input logic unit);
    logic [4:0] base;
    case (op)
      OP_SEEK: base = 5'(SR_SEEK_LSB);
      OP_READ: base = 5'(SR_READ_LSB);
      default: base = 5'(SR_WRITE_LSB);
    endcase
    return base + {4'b0000, unit};
  endfunction

endpackage

// File: rtl/fdc_rr_arb2.sv
// Two-requester round-robin grant with a last-grant pointer (resets to drive 1).
module fdc_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant_c,
  output logic       valid_c
);

  logic last;

  assign valid_c = |req;

  // On contention, favour the drive that was not granted last
  always_comb begin
    grant_c = req[1] & (~req[0] | ~last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (take) begin
      last <= grant_c;
    end
  end

endmodule

// File: rtl/fdc_disk_arbiter.sv
// Arbitrates two drive requesters onto one host command/status word pair.
// Define FDC_ARB_TIMEOUT_EN to bound the wait for a host answer to TIMEOUT_CYCLES.
module fdc_disk_arbiter
  import fdc_arb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
  parameter logic [7:0]  HOLDOFF_CYCLES = 8'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [CHS_W-1:0] req_chs0,
  input  logic [CHS_W-1:0] req_chs1,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic [SR_W-1:0]  disk_sr,
  input  logic [CR_W-1:0]  disk_cr,
  output logic             busy
);

  state_e          state, state_nxt;
  cmd_t            cmd, cmd_nxt;
  logic            unit, unit_nxt;
  logic [SR_W-1:0] sr_nxt;
  logic [1:0]      done_nxt, err_nxt;
  logic            busy_nxt;
  logic [7:0]      hold_cnt, hold_nxt;
  logic            take_c, grant_c, valid_c;
  logic            complete_c;

`ifdef FDC_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt, tmo_nxt;
  logic        timed_out_c;
  logic        unused_cr;
  assign unused_cr = ^{disk_cr[CR_W-1:5], disk_cr[2]};
`else
  logic unused_cr;
  assign unused_cr = ^{disk_cr[CR_W-1:5], disk_cr[2], TIMEOUT_CYCLES};
`endif

  fdc_rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .take    (take_c),
    .grant_c (grant_c),
    .valid_c (valid_c)
  );

  // Seek completes on the unit's own seek bit; read/write on the shared done bit
  always_comb begin
    if (cmd.op == OP_SEEK) begin
      complete_c = unit ? disk_cr[CR_SEEK1] : disk_cr[CR_SEEK0];
    end else begin
      complete_c = disk_cr[CR_RW_DONE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    unit_nxt  = unit;
    sr_nxt    = disk_sr;
    done_nxt  = 2'b00;
    err_nxt   = 2'b00;
    hold_nxt  = hold_cnt;
    take_c    = 1'b0;
`ifdef FDC_ARB_TIMEOUT_EN
    tmo_nxt     = tmo_cnt;
    timed_out_c = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (valid_c) begin
          take_c      = 1'b1;
          unit_nxt    = grant_c;
          cmd_nxt.op  = grant_c ? op_e'(req_op1) : op_e'(req_op0);
          cmd_nxt.chs = grant_c ? req_chs1 : req_chs0;
          state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd.op == OP_RSVD) begin
          // Reserved op never reaches the host
          done_nxt[unit] = 1'b1;
          err_nxt[unit]  = 1'b1;
          hold_nxt       = 8'd0;
          state_nxt      = ST_HOLDOFF;
        end else begin
          sr_nxt                         = {16'h0000, cmd.chs};
          sr_nxt[unit_bit(cmd.op, unit)] = 1'b1;
          state_nxt                      = ST_WAIT;
`ifdef FDC_ARB_TIMEOUT_EN
          tmo_nxt = 24'd0;
`endif
        end
      end
      ST_WAIT: begin
`ifdef FDC_ARB_TIMEOUT_EN
        tmo_nxt     = tmo_cnt + 24'd1;
        timed_out_c = (25'(tmo_cnt) + 25'd1) >= 25'(TIMEOUT_CYCLES);
        if (complete_c || timed_out_c) begin
          sr_nxt         = {16'h0000, disk_sr[CHS_W-1:0]};
          sr_nxt[SR_ACK] = 1'b1;
          done_nxt[unit] = 1'b1;
          err_nxt[unit]  = disk_cr[CR_ERR] | timed_out_c;
          state_nxt      = ST_ACK;
        end
`else
        if (complete_c) begin
          sr_nxt         = {16'h0000, disk_sr[CHS_W-1:0]};
          sr_nxt[SR_ACK] = 1'b1;
          done_nxt[unit] = 1'b1;
          err_nxt[unit]  = disk_cr[CR_ERR];
          state_nxt      = ST_ACK;
        end
`endif
      end
      ST_ACK: begin
        if (!disk_cr[CR_RW_DONE] && !disk_cr[CR_SEEK1] && !disk_cr[CR_SEEK0]) begin
          hold_nxt  = 8'd0;
          state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if ((9'(hold_cnt) + 9'd1) >= 9'(HOLDOFF_CYCLES)) begin
          state_nxt = ST_IDLE;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd      <= '0;
      unit     <= 1'b0;
      disk_sr  <= '0;
      done     <= 2'b00;
      err      <= 2'b00;
      busy     <= 1'b0;
      hold_cnt <= 8'd0;
`ifdef FDC_ARB_TIMEOUT_EN
      tmo_cnt  <= 24'd0;
`endif
    end else begin
      cmd      <= cmd_nxt;
      unit     <= unit_nxt;
      disk_sr  <= sr_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      hold_cnt <= hold_nxt;
`ifdef FDC_ARB_TIMEOUT_EN
      tmo_cnt  <= tmo_nxt;
`endif
    end
  end

endmodule

// File: doc/fdc_disk_arbiter.md
FDC_DISK_ARBITER -- requirements
Module: fdc_disk_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 24'd12_000_000, cycles allowed for the host to answer one command.
REQ-002 SHALL provide parameter HOLDOFF_CYCLES, default 8'd16, idle cycles inserted between consecutive host commands.
REQ-003 SHALL use one clock; reset is synchronous and active-high (ports clk, rst).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req[1:0]  input  2  per-drive request, level, held until done[n].
REQ-007 req_op0/req_op1  input  2 each  operation: 0 seek, 1 read sector, 2 write sector, 3 reserved.
REQ-008 req_chs0/req_chs1  input  16 each  {head, cylinder[6:0], sector_id[7:0]}.
REQ-009 done[1:0]  output  2  one-cycle completion pulse per drive.
REQ-010 err[1:0]  output  2  error flag, valid while done[n] is high.
REQ-011 disk_sr  output  32  host command word: [15:0] chs, [16] ack-of-ack, [18:17] read unit, [21:20] write unit, [25:24] seek unit.
REQ-012 disk_cr  input  32  host status word: [1:0] seek done per unit, [3] error, [4] read/write done.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, ISSUE, WAIT, ACK and HOLDOFF.
REQ-015 IDLE: if any req is high, SHALL grant one drive by round-robin, latching that drive's op and chs, and go to ISSUE next cycle.
REQ-016 Round-robin: when both requests are high, SHALL grant the drive not granted last; the last-grant pointer resets to drive 1, so drive 0 wins first.
REQ-017 Op 3 SHALL skip host traffic: done and err pulse for the granted drive one cycle after grant, then go to HOLDOFF.
REQ-018 ISSUE: SHALL write disk_sr[15:0]=chs, disk_sr[16]=0, set exactly one unit bit in the field selected by op (unit 0 sets bit 0 of the field, unit 1 sets bit 1), then go to WAIT.
REQ-019 WAIT, seek: SHALL complete when disk_cr[unit] is high.
REQ-020 WAIT, read/write: SHALL complete when disk_cr[4] is high.
REQ-021 ACK: on completion SHALL clear all unit bits in disk_sr, set disk_sr[16]=1, pulse done[unit], and drive err[unit]=disk_cr[3], all in one cycle.
REQ-022 ACK: SHALL then wait for disk_cr[4] and disk_cr[1:0] to be all low before entering HOLDOFF.
REQ-023 HOLDOFF: SHALL count HOLDOFF_CYCLES then return to IDLE; requests raised during HOLDOFF are held pending, not lost.
REQ-024 A requester dropping req mid-operation SHALL NOT abort the host command; the done pulse is still issued.
REQ-025 Completion and a new request in the same cycle: completion takes priority; the new request is arbitrated in IDLE.
REQ-026 Latency from req rising in IDLE to the unit bit set in disk_sr SHALL be exactly 2 cycles.

Reset
REQ-027 rst SHALL force state=IDLE, disk_sr=0, done=0, err=0, busy=0, last-grant=1, counters=0.
REQ-028 rst asserted mid-operation SHALL abandon the command without any done pulse.

Configuration
REQ-029 With FDC_ARB_TIMEOUT_EN defined, WAIT SHALL count cycles; at TIMEOUT_CYCLES it SHALL go to ACK with err[unit]=1 regardless of disk_cr[3].
REQ-030 Without FDC_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely and no timeout counter SHALL be synthesised.

Structure
REQ-031 Package fdc_arb_pkg SHALL hold the op codes, the state enum, and the disk_sr/disk_cr bit-index constants.
REQ-032 The round-robin grant logic SHALL be a sub-module, fdc_rr_arb2.

Verification
REQ-033 Single read: req0=1, op0=1, chs0=16'h0541 -> 2 cycles later disk_sr=32'h0002_0541; host sets disk_cr[4] -> done[0] pulses, err[0]=0, disk_sr[16]=1.
REQ-034 Contention: req=2'b11 from reset -> drive 0 served first, drive 1 issued after HOLDOFF_CYCLES+1 idle cycles.
REQ-035 Seek unit 1: op1=0 -> disk_sr[25:24]=2'b10; disk_cr[1]=1 with disk_cr[3]=1 -> done[1]=1, err[1]=1.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=100): no host answer -> done pulse with err=1 at cycle 100 of WAIT.
REQ-037 Reset mid-WAIT: rst for 1 cycle -> disk_sr=0, no done pulse, next request served normally.
REQ-038 Reserved op 3 -> done and err pulse, disk_sr unchanged.
